// File: rtl/branch_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_unit_pkg
// Description : Opcodes, branch condition codes and squash FSM states shared
//               by the Execute-stage redirect logic.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_redirect_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } bru_state_e;

endpackage : branch_redirect_unit_pkg
`default_nettype wire

// File: rtl/branch_redirect_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_unit_if
// Description : Decode-side inputs and redirect outputs of the Execute
//               branch unit. Counter signals exist only with BRU_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_redirect_unit_if;

    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] LinkE;
    logic        ValidE;
    logic        SquashE;
`ifdef BRU_PERF_EN
    logic [31:0] TakenCnt;
    logic [31:0] SquashCnt;
`endif

    modport master (
        output InstrD, PCD, PCPlus4D, RD1D, RD2D,
        input  PCSrcE, PCTargetE, LinkE, ValidE, SquashE
`ifdef BRU_PERF_EN
        , input TakenCnt, SquashCnt
`endif
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RD1D, RD2D,
        output PCSrcE, PCTargetE, LinkE, ValidE, SquashE
`ifdef BRU_PERF_EN
        , output TakenCnt, SquashCnt
`endif
    );

endinterface : branch_redirect_unit_if
`default_nettype wire

// File: rtl/branch_redirect_unit_imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : branch_imm_decode
// Description : Sign-extended B-, J- and I-immediates from an RV32I word.
//               Only bits [31:7] carry immediate data, so only they enter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_imm_decode (
    input  wire logic [31:7] instrHi,
    output logic      [31:0] bImm,
    output logic      [31:0] jImm,
    output logic      [31:0] iImm
);

    assign bImm = {{20{instrHi[31]}}, instrHi[7], instrHi[30:25], instrHi[11:8], 1'b0};
    assign jImm = {{12{instrHi[31]}}, instrHi[19:12], instrHi[20], instrHi[30:21], 1'b0};
    assign iImm = {{21{instrHi[31]}}, instrHi[30:20]};

endmodule : branch_imm_decode
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_unit
// Description : ID/EX register, branch/jump resolution and two-cycle squash
//               FSM. Optional event counters enabled by BRU_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    branch_redirect_unit_if.slave bus
);

    logic [31:0] r_instrE;
    logic [31:0] r_pcE;
    logic [31:0] r_pcPlus4E;
    logic [31:0] r_rd1E;
    logic [31:0] r_rd2E;
    bru_state_e  r_state;
    logic        r_squash;

    logic [31:0] w_bImm;
    logic [31:0] w_jImm;
    logic [31:0] w_iImm;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_valid;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_pcSrc;
    logic        w_load;

    branch_imm_decode u_imm (
        .instrHi (r_instrE[31:7]),
        .bImm    (w_bImm),
        .jImm    (w_jImm),
        .iImm    (w_iImm)
    );

    assign w_opcode = r_instrE[6:0];
    assign w_funct3 = r_instrE[14:12];
    assign w_valid  = (r_instrE != 32'h0);

    always_comb begin
        w_taken  = 1'b0;
        w_target = 32'h0;
        case (w_opcode)
            OPC_BRANCH: begin
                w_target = r_pcE + w_bImm;
                case (w_funct3)
                    F3_BEQ:  w_taken = (r_rd1E == r_rd2E);
                    F3_BNE:  w_taken = (r_rd1E != r_rd2E);
                    F3_BLT:  w_taken = ($signed(r_rd1E) <  $signed(r_rd2E));
                    F3_BGE:  w_taken = ($signed(r_rd1E) >= $signed(r_rd2E));
                    F3_BLTU: w_taken = (r_rd1E <  r_rd2E);
                    F3_BGEU: w_taken = (r_rd1E >= r_rd2E);
                    default: w_taken = 1'b0;
                endcase
            end
            OPC_JAL: begin
                w_taken  = 1'b1;
                w_target = r_pcE + w_jImm;
            end
            OPC_JALR: begin
                w_taken  = (w_funct3 == F3_JALR);
                w_target = (r_rd1E + w_iImm) & 32'hFFFF_FFFE;
            end
            default: begin
                w_taken  = 1'b0;
                w_target = 32'h0;
            end
        endcase
    end

    assign w_pcSrc = w_valid & w_taken;
    // While squashing or redirecting, the D-stage word is wrong-path.
    assign w_load  = (r_state == ST_RUN) && !w_pcSrc;

    always_ff @(posedge clk) begin
        if (!rst || !w_load) begin
            r_instrE   <= 32'h0;
            r_pcE      <= 32'h0;
            r_pcPlus4E <= 32'h0;
            r_rd1E     <= 32'h0;
            r_rd2E     <= 32'h0;
        end else begin
            r_instrE   <= bus.InstrD;
            r_pcE      <= bus.PCD;
            r_pcPlus4E <= bus.PCPlus4D;
            r_rd1E     <= bus.RD1D;
            r_rd2E     <= bus.RD2D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_squash <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_state  <= w_pcSrc ? ST_SQUASH : ST_RUN;
                    r_squash <= w_pcSrc;
                end
                ST_SQUASH: begin
                    r_state  <= ST_RUN;
                    r_squash <= 1'b0;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_squash <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCSrcE    = w_pcSrc;
    assign bus.PCTargetE = w_pcSrc ? w_target : 32'h0;
    assign bus.LinkE     = r_pcPlus4E;
    assign bus.ValidE    = w_valid;
    assign bus.SquashE   = r_squash;

`ifdef BRU_PERF_EN
    logic [31:0] r_takenCnt;
    logic [31:0] r_squashCnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_takenCnt  <= 32'h0;
            r_squashCnt <= 32'h0;
        end else begin
            if (w_pcSrc) begin
                r_takenCnt <= r_takenCnt + 32'd1;
            end
            if (!w_load && (bus.InstrD != 32'h0)) begin
                r_squashCnt <= r_squashCnt + 32'd1;
            end
        end
    end

    assign bus.TakenCnt  = r_takenCnt;
    assign bus.SquashCnt = r_squashCnt;
`endif

endmodule : branch_redirect_unit
`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_unit
// Description : Directed plus randomized check of branch_redirect_unit
//               against an ISA-level reference model (BRU_PERF_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_unit;

    logic clk;
    logic rst;
    int   nChecks;
    int   nErrors;

    branch_redirect_unit_if bus ();

    branch_redirect_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of Execute plus a count of pending bubbles.
    logic [31:0] mInstr, mPc, mPc4, mRd1, mRd2;
    int          mPend;
    bit          mSq;
    logic [31:0] mTakenCnt, mSquashCnt;

    function automatic logic [32:0] resolve(input logic [31:0] ins, pc, a, b);
        logic [12:0] bf;
        logic [20:0] jf;
        logic [11:0] ifl;
        int          bi, ji, ii;
        bit          tk;
        logic [31:0] t;
        bf  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        jf  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ifl = ins[31:20];
        bi  = $signed(bf);
        ji  = $signed(jf);
        ii  = $signed(ifl);
        tk  = 0;
        t   = 0;
        if (ins != 0) begin
            case (ins[6:0])
                7'h63: begin
                    case (ins[14:12])
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = ($signed(a) <  $signed(b));
                        3'd5: tk = ($signed(a) >= $signed(b));
                        3'd6: tk = (a <  b);
                        3'd7: tk = (a >= b);
                        default: tk = 0;
                    endcase
                    t = pc + bi;
                end
                7'h6F: begin tk = 1; t = pc + ji; end
                7'h67: begin tk = (ins[14:12] == 3'd0); t = (a + ii) & 32'hFFFF_FFFE; end
                default: tk = 0;
            endcase
        end
        if (!tk) t = 0;
        return {tk, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge();
        logic [32:0] r;
        r = resolve(mInstr, mPc, mRd1, mRd2);
        if (!rst) begin
            {mInstr, mPc, mPc4, mRd1, mRd2} = '0;
            mPend = 0; mSq = 0; mTakenCnt = 0; mSquashCnt = 0;
        end else if (r[32] || mPend > 0) begin
            if (bus.InstrD != 0) mSquashCnt++;
            if (r[32]) mTakenCnt++;
            mPend = r[32] ? 1 : 0;
            mSq   = r[32];
            {mInstr, mPc, mPc4, mRd1, mRd2} = '0;
        end else begin
            mInstr = bus.InstrD; mPc = bus.PCD; mPc4 = bus.PCPlus4D;
            mRd1 = bus.RD1D; mRd2 = bus.RD2D;
            mSq = 0;
        end
    endtask

    task automatic compareAll();
        logic [32:0] r;
        r = resolve(mInstr, mPc, mRd1, mRd2);
        chk("PCSrcE",    {31'b0, bus.PCSrcE},  {31'b0, r[32]});
        chk("PCTargetE", bus.PCTargetE,        r[31:0]);
        chk("LinkE",     bus.LinkE,            mPc4);
        chk("ValidE",    {31'b0, bus.ValidE},  {31'b0, (mInstr != 0)});
        chk("SquashE",   {31'b0, bus.SquashE}, {31'b0, mSq});
`ifdef BRU_PERF_EN
        chk("TakenCnt",  bus.TakenCnt,  mTakenCnt);
        chk("SquashCnt", bus.SquashCnt, mSquashCnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic drive(input logic [31:0] ins, pc, a, b);
        bus.InstrD = ins; bus.PCD = pc; bus.PCPlus4D = pc + 32'd4;
        bus.RD1D = a; bus.RD2D = b;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] x;
        int          k;
        x = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0:       x = 32'h0;
            1, 2, 3: x[6:0] = 7'h63;
            4:       x[6:0] = 7'h6F;
            5:       begin x[6:0] = 7'h67; x[14:12] = 3'd0; end
            6:       x[6:0] = 7'h67;
            default: x[6:0] = 7'h13;
        endcase
        return x;
    endfunction

    initial begin
        logic [31:0] a;
        nChecks = 0;
        nErrors = 0;
        mPend = 0; mSq = 0;

        // Reset with a self-targeting beq sitting in D
        rst = 1'b0;
        drive(32'h0000_0063, 32'h0, 32'h0, 32'h0);
        step();
        step();
        chk("rst_PCSrcE",    {31'b0, bus.PCSrcE}, 32'h0);
        chk("rst_PCTargetE", bus.PCTargetE, 32'h0);
        chk("rst_LinkE",     bus.LinkE, 32'h0);
        chk("rst_ValidE",    {31'b0, bus.ValidE}, 32'h0);
        chk("rst_SquashE",   {31'b0, bus.SquashE}, 32'h0);

        // BEQ taken, then two squashed nops
        rst = 1'b1;
        drive(32'h0020_8463, 32'h100, 32'd5, 32'd5);
        step();
        chk("beq_PCSrcE",    {31'b0, bus.PCSrcE}, 32'h1);
        chk("beq_PCTargetE", bus.PCTargetE, 32'h108);
        drive(32'h0000_0013, 32'h104, 32'd0, 32'd0);
        step();
        chk("beq_bubble1",   {31'b0, bus.ValidE}, 32'h0);
        chk("beq_SquashE",   {31'b0, bus.SquashE}, 32'h1);
        drive(32'h0000_0013, 32'h108, 32'd0, 32'd0);
        step();
        chk("beq_bubble2",   {31'b0, bus.ValidE}, 32'h0);
`ifdef BRU_PERF_EN
        chk("beq_SquashCnt", bus.SquashCnt, 32'd2);
`endif

        // BLT taken on signed compare
        drive(32'h0020_C463, 32'h200, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("blt_PCSrcE",    {31'b0, bus.PCSrcE}, 32'h1);
        chk("blt_PCTargetE", bus.PCTargetE, 32'h208);
        drive(32'h0000_0013, 32'h204, 32'd0, 32'd0);
        step();
        step();
        // BLTU not taken, follower enters E without a bubble
        drive(32'h0020_E463, 32'h300, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("bltu_PCSrcE",    {31'b0, bus.PCSrcE}, 32'h0);
        chk("bltu_PCTargetE", bus.PCTargetE, 32'h0);
        drive(32'h0000_0013, 32'h304, 32'd0, 32'd0);
        step();
        chk("bltu_follow_ValidE", {31'b0, bus.ValidE}, 32'h1);
        chk("bltu_follow_LinkE",  bus.LinkE, 32'h308);

        // JALR clears bit 0 of the sum
        drive(32'h0030_8067, 32'h40, 32'h2001, 32'd0);
        step();
        chk("jalr_PCTargetE", bus.PCTargetE, 32'h2004);
        chk("jalr_LinkE",     bus.LinkE, 32'h44);
        drive(32'h0000_0013, 32'h44, 32'd0, 32'd0);
        step();
        step();

        // JAL -8 from 0x4 wraps
        drive(32'hFF9F_F06F, 32'h4, 32'd0, 32'd0);
        step();
        chk("jal_wrap_PCTargetE", bus.PCTargetE, 32'hFFFF_FFFC);
        drive(32'h0000_0013, 32'h8, 32'd0, 32'd0);
        step();
        step();

        // Reset on the edge after a taken branch abandons the squash
        drive(32'h0020_8463, 32'h500, 32'd7, 32'd7);
        step();
        chk("midsq_PCSrcE", {31'b0, bus.PCSrcE}, 32'h1);
        rst = 1'b0;
        drive(32'h0000_0013, 32'h504, 32'd0, 32'd0);
        step();
        chk("midsq_SquashE", {31'b0, bus.SquashE}, 32'h0);
        rst = 1'b1;
        drive(32'h0000_0013, 32'h600, 32'd0, 32'd0);
        step();
        chk("midsq_ValidE", {31'b0, bus.ValidE}, 32'h1);
        chk("midsq_LinkE",  bus.LinkE, 32'h604);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            a = $urandom;
            drive(randInstr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, a,
                  ($urandom_range(0, 2) == 0) ? a : 32'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule : tb_branch_redirect_unit
`default_nettype wire

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Execute-side counterpart of the fetch stage in the 5-stage RV32I pipeline. It captures the decode-stage instruction into its own ID/EX register and resolves control flow in Execute: BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR. It drives the PC redirect pair (`PCSrcE`, `PCTargetE`) back into fetch. Because fetch has no flush input, a two-state squash FSM turns the two wrong-path instructions that follow a taken redirect into bubbles.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset, sampled on posedge `clk`.
- `InstrD` in 32: decode-stage instruction; 32'h00000000 is a bubble.
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: `PCD`+4.
- `RD1D` in 32: rs1 value from the register file.
- `RD2D` in 32: rs2 value from the register file.
- `PCSrcE` out 1: redirect request to fetch; 1 selects `PCTargetE`.
- `PCTargetE` out 32: redirect target.
- `LinkE` out 32: PC+4 of the Execute instruction (rd value for JAL/JALR).
- `ValidE` out 1: Execute holds a real (non-bubble) instruction.
- `SquashE` out 1: FSM is in SQUASH.
- `TakenCnt` out 32: taken redirects (only with `BRU_PERF_EN`).
- `SquashCnt` out 32: squashed instructions (only with `BRU_PERF_EN`).

## Operation
- ID/EX register: `InstrE`, `PCE`, `PCPlus4E`, `RD1E`, `RD2E`.
  - Loads the D-stage values when the load condition holds.
  - Otherwise it loads all zeros, which is a bubble.
  - Load condition: `rst`=1, state RUN, and `PCSrcE`=0.
- `ValidE` = (`InstrE` != 0).
- Decode of `InstrE`:
  - opcode 1100011 is a branch; funct3 selects the condition.
  - Conditions: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - funct3 010 and 011 are never taken.
  - 1101111 is JAL, always taken.
  - 1100111 with funct3 000 is JALR, always taken.
  - Any other opcode is never taken.
- Targets:
  - Branch: `PCE` + B-imm.
  - JAL: `PCE` + J-imm.
  - JALR: (`RD1E` + I-imm) with bit 0 cleared.
  - All sums are modulo 2^32; wrap-around is silent.
  - Immediates are sign-extended to 32 bits.
- `PCSrcE` = `ValidE` AND taken. When `PCSrcE`=0, `PCTargetE` = 0.
- FSM:
  - RUN: `PCSrcE`=1 → SQUASH; else stay in RUN.
  - SQUASH: → RUN unconditionally.
  - Net effect: a taken redirect in cycle n forces bubbles into E at the n+1 and n+2 edges.
- Reset values (after any posedge with `rst`=0):
  - ID/EX register all zero; state RUN.
  - `PCSrcE`=0, `PCTargetE`=0, `LinkE`=0, `ValidE`=0, `SquashE`=0.
  - Counters 0.
  - Reset mid-squash abandons the squash.
- No misalignment trap: targets with bit 1 set are issued as computed.

## Timing
- Redirect latency: control instruction in D in cycle n, in E and resolved in cycle n+1.
  - `PCSrcE`, `PCTargetE`, `LinkE` are combinational from the E register, valid within cycle n+1.
- Fetch loads the target at the n+2 edge. The target reaches E at cycle n+4.
- Branch penalty is exactly 2 cycles. E holds bubbles in cycles n+2 and n+3.
- `SquashE`=1 during cycle n+2.
- Back-to-back redirects are impossible: the instruction behind a taken one is always squashed.
- A not-taken branch has zero penalty.

## Configuration
- `BRU_PERF_EN` defined:
  - `TakenCnt` increments on each edge where `PCSrcE`=1.
  - `SquashCnt` increments by 1 on each edge where the E register is loaded with a bubble in place of a nonzero `InstrD`.
  - Both are 32-bit, wrap silently, and reset to 0.
- `BRU_PERF_EN` undefined: both counters and their ports are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - opcode constants `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`;
  - the funct3 condition codes;
  - FSM state encodings `ST_RUN`, `ST_SQUASH`.
- One combinational sub-module, `branch_imm_decode`: `InstrE` → sign-extended B-, J- and I-immediates.

## Test plan
- Reset: hold `rst`=0 for 2 edges with `InstrD`=32'h00000063.
  - Response: all outputs 0 and state RUN.
- BEQ taken: `InstrD`=32'h00208463 (beq x1,x2,+8), `PCD`=32'h100, `RD1D`=`RD2D`=5.
  - Next cycle: `PCSrcE`=1, `PCTargetE`=32'h108.
  - The next two cycles: `ValidE`=0.
  - `SquashCnt`=2.
- BLTU vs BLT: `RD1D`=32'hFFFFFFFF, `RD2D`=1.
  - BLT taken; BLTU not taken (`PCSrcE`=0, `PCTargetE`=0).
  - The following instruction reaches E with no bubble.
- JALR: `InstrD`=32'h00308067, `RD1D`=32'h2001, `PCD`=32'h40.
  - `PCTargetE`=32'h2004 (bit 0 cleared), `LinkE`=32'h44.
- Wrap: JAL imm −8 at `PCD`=32'h4.
  - `PCTargetE`=32'hFFFFFFFC.
- Reset mid-squash: assert `rst`=0 on the edge after a taken branch.
  - Next cycle: state RUN, `SquashE`=0.
  - Next valid `InstrD` after release reaches E without a bubble.
